// File: rtl/mux_pkg.sv
// Shared types and the wrapping priority search for mux_rr_stream.
// Packet locking is enabled by defining MUX_RR_STREAM_PKT_LOCK_EN.
package mux_pkg;

    localparam int unsigned MAX_N = 16;

    typedef enum logic {EMPTY, FULL} out_state_e;
    typedef enum logic {ARB, LOCK} arb_state_e;

    // One-hot pick of the first set req bit after ptr, wrapping modulo n (n <= MAX_N).
    function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                                 input logic [4:0]       n,
                                                 input logic [4:0]       ptr);
        logic [MAX_N-1:0] gnt;
        logic             found;
        logic [4:0]       idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 1; i <= int'(MAX_N); i++) begin
            idx = ptr + 5'(i);
            if (idx >= n) idx = idx - n;
            if (!found && (5'(i) <= n) && req[idx[3:0]]) begin
                gnt[idx[3:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter owning the priority pointer and, with
// MUX_RR_STREAM_PKT_LOCK_EN defined, the packet lock FSM.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = 3,
    localparam int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    input  logic          upd_i,
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
    input  logic          last_i,
`endif
    output logic [N-1:0]  gnt_o,
    output logic [CW-1:0] idx_o
);

    logic [CW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  rr_gnt;

    assign rr_gnt = N'(rr_pick(MAX_N'(req_i), 5'(N), 5'(ptr_q)));

`ifdef MUX_RR_STREAM_PKT_LOCK_EN
    arb_state_e state_q, state_d;
    logic [N-1:0] lock_mask;

    // While locked, ptr_q still holds the owning channel from its last transfer.
    assign lock_mask = N'(1) << ptr_q;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        gnt_o = '0;
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
        state_d = state_q;
        if (en_i) gnt_o = (state_q == LOCK) ? (req_i & lock_mask) : rr_gnt;
        if (upd_i) state_d = last_i ? ARB : LOCK;
`else
        if (en_i) gnt_o = rr_gnt;
`endif
    end

    always_comb begin
        idx_o = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_o[k]) idx_o = CW'(k);
        end
        ptr_d = upd_i ? idx_o : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ptr_q <= CW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

`ifdef MUX_RR_STREAM_PKT_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ARB;
        else        state_q <= state_d;
    end
`endif

endmodule

// File: rtl/mux_rr_stream.sv
// N:1 round-robin streaming mux with one registered output stage.
// Define MUX_RR_STREAM_PKT_LOCK_EN to add in_last/out_last and packet locking.
module mux_rr_stream
    import mux_pkg::*;
#(
    parameter  int N  = 3,
    parameter  int W  = 8,
    localparam int CW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
    input  logic [N-1:0]   in_last,
    output logic           out_last,
`endif
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CW-1:0]  out_chan
);

    out_state_e    state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] chan_q, chan_d;
    logic [CW-1:0] idx;
    logic          load, xfer;

    assign load = (state_q == EMPTY) || out_ready;
    assign xfer = |(in_valid & in_ready);

    rr_arbiter #(.N(N)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (in_valid),
        .en_i  (load && rst_n),
        .upd_i (xfer),
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
        .last_i(|(in_last & in_ready)),
`endif
        .gnt_o (in_ready),
        .idx_o (idx)
    );

`ifdef MUX_RR_STREAM_PKT_LOCK_EN
    logic last_q, last_d;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
        last_d  = last_q;
`endif
        case (state_q)
            EMPTY:   if (xfer) state_d = FULL;
            FULL:    if (!xfer && out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (xfer) begin
            chan_d = idx;
            // in_ready is one-hot, so this reduces to an AND-OR mux.
            data_d = '0;
            for (int k = 0; k < N; k++) begin
                if (in_ready[k]) data_d = data_d | in_data[k*W +: W];
            end
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
            last_d = |(in_last & in_ready);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, since out_data/out_chan are visible as 0 in reset.
            state_q <= EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
            last_q  <= last_d;
`endif
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_chan  = chan_q;
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
    assign out_last  = last_q;
`endif

endmodule

// File: tb/tb_mux_rr_stream.sv
// Scoreboard bench for mux_rr_stream (N=3, W=8); lock test runs when
// MUX_RR_STREAM_PKT_LOCK_EN is defined.
module tb_mux_rr_stream;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int CW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   in_last = '1;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [CW-1:0]  out_chan;
    logic           out_last;

    always #5 clk = ~clk;

    mux_rr_stream #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
        .in_last  (in_last),
        .out_last (out_last),
`endif
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_chan (out_chan)
    );

`ifndef MUX_RR_STREAM_PKT_LOCK_EN
    assign out_last = 1'b1;
`endif

    typedef struct {
        int         chan;
        logic [W-1:0] data;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    m_ptr = N - 1;     // last granted channel in the model
    bit    m_full = 1'b0;     // model: output register holds a beat
    int    lock_chan = -1;    // model: channel owning an open packet, or -1
    int    wait_cnt[N];
    bit    mon_en = 1'b0;
    bit    chk_starve = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: applies inputs, checks the grant against the model,
    // books the expected beat at the following posedge, returns at the next negedge.
    task automatic drive_cycle(input logic [N-1:0] v, input logic rdy,
                               input logic [N*W-1:0] d, input logic [N-1:0] l,
                               output int g);
        in_valid  = v;
        out_ready = rdy;
        in_data   = d;
        in_last   = l;
        #1;
        g = -1;
        if (!m_full || rdy) begin
            if (lock_chan >= 0) begin
                if (v[lock_chan]) g = lock_chan;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    int c;
                    c = (m_ptr + i) % N;
                    if (g < 0 && v[c]) g = c;
                end
            end
        end
        check("in_ready", 64'(in_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        if (chk_starve && g >= 0) begin
            for (int c = 0; c < N; c++) begin
                if (c == g || !v[c]) wait_cnt[c] = 0;
                else begin
                    wait_cnt[c]++;
                    check("starvation_bound", 64'(wait_cnt[c] <= N - 1), 64'd1);
                end
            end
        end
        @(posedge clk);
        if (g >= 0) begin
            exp_q.push_back('{chan: g, data: d[g*W +: W], last: l[g]});
            m_ptr  = g;
            m_full = 1'b1;
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
            lock_chan = l[g] ? -1 : g;
`endif
        end else if (rdy) begin
            m_full = 1'b0;
        end
        @(negedge clk);
    endtask

    // Called at a negedge: asserts reset mid-cycle, checks the async clear, releases.
    task automatic do_reset();
        mon_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_chan",  64'(out_chan),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        @(negedge clk);
        in_valid  = '1;
        out_ready = 1'b1;
        #1;
        check("in_ready_held_in_reset", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_ptr     = N - 1;
        m_full    = 1'b0;
        lock_chan = -1;
        foreach (wait_cnt[c]) wait_cnt[c] = 0;
        mon_en = 1'b1;
    endtask

    // Monitor: compares the presented beat with the scoreboard head every cycle,
    // retiring it only when the consumer accepts it.
    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("out_chan", 64'(out_chan), 64'(exp_q[0].chan));
                check("out_data", 64'(out_data), 64'(exp_q[0].data));
`ifdef MUX_RR_STREAM_PKT_LOCK_EN
                check("out_last", 64'(out_last), 64'(exp_q[0].last));
`endif
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    localparam logic [N*W-1:0] DATA_ABC = {8'hC2, 8'hB1, 8'hA0};
    localparam logic [N*W-1:0] DATA_5C  = {8'h5C, 8'h00, 8'h00};

    initial begin
        int g;
        logic [N*W-1:0] rd;

        @(negedge clk);
        do_reset();

        // Lone valid on channel 2 wins from reset; the next search starts at 0.
        drive_cycle(3'b100, 1'b1, DATA_5C, '1, g);
        check("single_valid_grant", 64'(g), 64'd2);
        drive_cycle(3'b111, 1'b1, DATA_ABC, '1, g);
        check("wrap_to_zero", 64'(g), 64'd0);

        // Mid-cycle async reset with a beat in flight.
        do_reset();

        // All valid, out_ready high: strict 0,1,2 rotation, one beat per cycle.
        for (int k = 0; k < 6; k++) begin
            drive_cycle(3'b111, 1'b1, DATA_ABC, '1, g);
            check("rr_order", 64'(g), 64'(k % N));
        end

        // Stall for 4 cycles, then resume.
        for (int k = 0; k < 4; k++) drive_cycle(3'b111, 1'b0, DATA_ABC, '1, g);
        drive_cycle(3'b111, 1'b1, DATA_ABC, '1, g);
        check("resume_order", 64'(g), 64'd0);

        // Randomised valid/ready/data.
        chk_starve = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < N; c++) rd[c*W +: W] = W'($urandom);
            drive_cycle(N'($urandom), ($urandom_range(0, 3) != 0), rd, '1, g);
        end
        chk_starve = 1'b0;

`ifdef MUX_RR_STREAM_PKT_LOCK_EN
        // Channel 1 sends a 3-beat packet while channel 0 waits.
        do_reset();
        drive_cycle(3'b010, 1'b1, DATA_ABC, 3'b000, g);
        check("pkt_beat1", 64'(g), 64'd1);
        drive_cycle(3'b011, 1'b1, DATA_ABC, 3'b000, g);
        check("pkt_beat2", 64'(g), 64'd1);
        drive_cycle(3'b011, 1'b1, DATA_ABC, 3'b010, g);
        check("pkt_beat3", 64'(g), 64'd1);
        drive_cycle(3'b011, 1'b1, DATA_ABC, 3'b011, g);
        check("pkt_after", 64'(g), 64'd0);
`endif

        // Drain and confirm nothing is left outstanding.
        for (int k = 0; k < 3; k++) drive_cycle('0, 1'b1, '0, '1, g);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
